// File: rtl/uart_sample_rx.sv
// UART 8N1 receiver that pairs accepted bytes into signed (re, im) samples and numbers them within an N-sample frame.
// Optional idle-timeout resync is built only when UART_RX_TIMEOUT_EN is defined.
module uart_sample_rx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int N            = 256,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [7:0]           sample_re_o,
  output logic [7:0]           sample_im_o,
  output logic                 sample_valid_o,
  output logic [$clog2(N)-1:0] sample_idx_o,
  output logic                 frame_done_o,
  output logic                 frame_err_o
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  if (CLKS_PER_BIT < 4 || N < 2 || N > 4096 || (N & (N - 1)) != 0 || TIMEOUT_BITS < 1) begin : g_bad_param
    $error("uart_sample_rx: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic          sync1, sync2, rx_prev;
  logic          rx_s, fall;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    re_hold;
  logic          have_re;
  logic          armed;
  logic [IW-1:0] idx_cnt;
  logic          to_hit;

  assign rx_s = sync2;
  assign fall = rx_prev & ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] idle_cnt;
  logic        to_pending;

  assign to_pending = (state == IDLE) && rx_s && (have_re || (idx_cnt != '0));
  assign to_hit     = to_pending && (idle_cnt == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (to_pending && !to_hit) begin
      idle_cnt <= idle_cnt + 32'd1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // armed stays low after reset until the line has idled a full bit, so a byte
  // already in flight at release cannot be mistaken for a fresh start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      re_hold        <= '0;
      have_re        <= 1'b0;
      armed          <= 1'b0;
      idx_cnt        <= '0;
      sample_re_o    <= '0;
      sample_im_o    <= '0;
      sample_idx_o   <= '0;
      sample_valid_o <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      sample_valid_o <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (to_hit) begin
            have_re <= 1'b0;
            idx_cnt <= '0;
          end
          if (!armed) begin
            if (!rx_s) begin
              clk_cnt <= '0;
            end else if (clk_cnt == BIT_M1) begin
              armed   <= 1'b1;
              clk_cnt <= '0;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end else if (fall) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!have_re) begin
                re_hold <= shreg;
                have_re <= 1'b1;
              end else begin
                sample_re_o    <= re_hold;
                sample_im_o    <= shreg;
                sample_idx_o   <= idx_cnt;
                sample_valid_o <= 1'b1;
                frame_done_o   <= (idx_cnt == IDX_LAST);
                idx_cnt        <= idx_cnt + IW'(1);
                have_re        <= 1'b0;
              end
            end else begin
              // Framing error: the held real byte is dropped, the index is kept.
              state       <= BREAK;
              frame_err_o <= 1'b1;
              have_re     <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (!rx_s) begin
            clk_cnt <= '0;
          end else if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule
